// File: rtl/mic1_pkg.sv
// Shared MIC-1 sequencer types: microinstruction layout, sequencer states and
// the table of legal ALU function codes.
package mic1_pkg;

    localparam int SEQ_ADDR_W = 9;
    localparam int SEQ_MIR_W  = 36;

    // Field order mirrors the MIR bit map, MSB first (NEXT_ADDR at [35:27], B at [3:0]).
    typedef struct packed {
        logic [8:0] next_addr;
        logic       jmpc;
        logic       jamn;
        logic       jamz;
        logic       sll8;
        logic       sra1;
        logic       f0;
        logic       f1;
        logic       ena;
        logic       enb;
        logic       inva;
        logic       inc;
        logic [8:0] c;
        logic       write;
        logic       read;
        logic       fetch;
        logic [3:0] b;
    } mir_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        EXEC  = 3'd3,
        WAIT  = 3'd4,
        HALT  = 3'd5
    } state_t;

    // {F0,F1,ENA,ENB,INVA,INC} encodings the MIC-1 ALU defines.
    localparam logic [5:0] LEGAL_ALU [16] = '{
        6'b011000, 6'b010100, 6'b011010, 6'b101100,
        6'b111100, 6'b111101, 6'b111001, 6'b110101,
        6'b111111, 6'b110110, 6'b111011, 6'b001100,
        6'b011100, 6'b010000, 6'b110001, 6'b110010
    };

    function automatic logic is_legal_alu(input logic [5:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (LEGAL_ALU[i] == code) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/mic1_sequencer_next_addr.sv
// Combinational next-MPC logic: NEXT_ADDR with the JAMN/JAMZ bit OR-ed into the
// MSB and, for JMPC, the MBR byte OR-ed into the low bits (never carries).
module mic1_next_addr #(
    parameter int ADDR_W = 9
) (
    input  logic [ADDR_W-1:0] next_addr,
    input  logic              jmpc,
    input  logic              jamn,
    input  logic              jamz,
    input  logic              n,
    input  logic              z,
    input  logic [ADDR_W-2:0] mbr,
    output logic [ADDR_W-1:0] next_mpc
);

    // Build the jump target by OR-ing condition bits into NEXT_ADDR.
    always_comb begin
        next_mpc[ADDR_W-1] = next_addr[ADDR_W-1] | (jamn & n) | (jamz & z);
        if (jmpc) begin
            next_mpc[ADDR_W-2:0] = next_addr[ADDR_W-2:0] | mbr;
        end else begin
            next_mpc[ADDR_W-2:0] = next_addr[ADDR_W-2:0];
        end
    end

endmodule

// File: rtl/mic1_sequencer.sv
// MIC-1 microsequencer: FETCH/LOAD/EXEC(/WAIT) loop over an external control store.
// Optional illegal-ALU-code trap enabled by defining MIC1_SEQ_ILLEGAL_ALU_CHECK_EN.
module mic1_sequencer
    import mic1_pkg::*;
#(
    parameter int                ADDR_W     = SEQ_ADDR_W,
    parameter int                MIR_W      = SEQ_MIR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] cs_addr,
    output logic              cs_rd,
    input  logic [MIR_W-1:0]  cs_data,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic [ADDR_W-2:0] mbr,
    input  logic              mem_ready,
    output logic              f0,
    output logic              f1,
    output logic              ena,
    output logic              enb,
    output logic              inva,
    output logic              inc,
    output logic              sll8,
    output logic              sra1,
    output logic [8:0]        c_en,
    output logic [3:0]        b_sel,
    output logic              mem_write,
    output logic              mem_read,
    output logic              mem_fetch,
    output logic [ADDR_W-1:0] mpc,
    output logic              busy,
    output logic              halted,
    output logic              err_illegal
);

    state_t            state_r;
    logic [ADDR_W-1:0] mpc_r;
    // Sequencing half of MIR; the datapath half lives in the output registers.
    logic [ADDR_W-1:0] next_addr_r;
    logic              jmpc_r;
    logic              jamn_r;
    logic              jamz_r;
    logic              mem_op_r;
    logic              illegal_r;
    logic              err_r;
    logic              n_r;
    logic              z_r;

    mir_t              cs_mir_s;
    logic              illegal_s;
    logic              n_sel_s;
    logic              z_sel_s;
    logic              halt_cond_s;
    logic [ADDR_W-1:0] next_mpc_s;

    assign cs_mir_s    = cs_data;
    assign cs_addr     = mpc_r;
    assign mpc         = mpc_r;
    assign err_illegal = err_r;

`ifdef MIC1_SEQ_ILLEGAL_ALU_CHECK_EN
    assign illegal_s = ~is_legal_alu({cs_mir_s.f0, cs_mir_s.f1, cs_mir_s.ena,
                                      cs_mir_s.enb, cs_mir_s.inva, cs_mir_s.inc});
`else
    assign illegal_s = 1'b0;
`endif

    // In EXEC the flags being latched this cycle are the ones the jump must see.
    always_comb begin
        if (state_r == EXEC) begin
            n_sel_s = alu_n;
            z_sel_s = alu_z;
        end else begin
            n_sel_s = n_r;
            z_sel_s = z_r;
        end
    end

    assign halt_cond_s = ~jmpc_r & ~jamn_r & ~jamz_r & ~mem_op_r & (next_addr_r == mpc_r);

    mic1_next_addr #(.ADDR_W(ADDR_W)) u_next_addr (
        .next_addr (next_addr_r),
        .jmpc      (jmpc_r),
        .jamn      (jamn_r),
        .jamz      (jamz_r),
        .n         (n_sel_s),
        .z         (z_sel_s),
        .mbr       (mbr),
        .next_mpc  (next_mpc_s)
    );

    // Sequencer state machine; datapath outputs are loaded at the LOAD->EXEC edge
    // so they are registered and visible for exactly the EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            mpc_r       <= RESET_ADDR;
            next_addr_r <= '0;
            jmpc_r      <= 1'b0;
            jamn_r      <= 1'b0;
            jamz_r      <= 1'b0;
            mem_op_r    <= 1'b0;
            illegal_r   <= 1'b0;
            err_r       <= 1'b0;
            n_r         <= 1'b0;
            z_r         <= 1'b0;
            {f0, f1, ena, enb, inva, inc} <= 6'b000000;
            sll8        <= 1'b0;
            sra1        <= 1'b0;
            c_en        <= 9'h000;
            b_sel       <= 4'h0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_fetch   <= 1'b0;
            cs_rd       <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            {f0, f1, ena, enb, inva, inc} <= 6'b000000;
            sll8      <= 1'b0;
            sra1      <= 1'b0;
            c_en      <= 9'h000;
            b_sel     <= 4'h0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_fetch <= 1'b0;
            cs_rd     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (run) begin
                        state_r <= FETCH;
                        cs_rd   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    state_r <= LOAD;
                end
                LOAD: begin
                    state_r     <= EXEC;
                    next_addr_r <= cs_mir_s.next_addr;
                    jmpc_r      <= cs_mir_s.jmpc;
                    jamn_r      <= cs_mir_s.jamn;
                    jamz_r      <= cs_mir_s.jamz;
                    mem_op_r    <= (cs_mir_s.write | cs_mir_s.read | cs_mir_s.fetch) & ~illegal_s;
                    illegal_r   <= illegal_s;
                    err_r       <= err_r | illegal_s;
                    {f0, f1, ena, enb, inva, inc} <= {cs_mir_s.f0, cs_mir_s.f1, cs_mir_s.ena,
                                                      cs_mir_s.enb, cs_mir_s.inva, cs_mir_s.inc};
                    sll8        <= cs_mir_s.sll8;
                    sra1        <= cs_mir_s.sra1;
                    c_en        <= illegal_s ? 9'h000 : cs_mir_s.c;
                    b_sel       <= cs_mir_s.b;
                    mem_write   <= cs_mir_s.write & ~illegal_s;
                    mem_read    <= cs_mir_s.read  & ~illegal_s;
                    mem_fetch   <= cs_mir_s.fetch & ~illegal_s;
                end
                EXEC: begin
                    n_r <= alu_n;
                    z_r <= alu_z;
                    if (illegal_r) begin
                        state_r <= HALT;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                    end else if (mem_op_r) begin
                        state_r <= WAIT;
                    end else begin
                        mpc_r <= next_mpc_s;
                        if (halt_cond_s) begin
                            state_r <= HALT;
                            busy    <= 1'b0;
                            halted  <= 1'b1;
                        end else if (run) begin
                            state_r <= FETCH;
                            cs_rd   <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        mpc_r <= next_mpc_s;
                        if (run) begin
                            state_r <= FETCH;
                            cs_rd   <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                HALT: begin
                    state_r <= HALT;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic1_sequencer.sv
// Scoreboard bench for mic1_sequencer: a control-store model plus a monitor that
// checks every fetch address/spacing and every EXEC control word against queues.
module tb_mic1_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, cs_rd, alu_n, alu_z, mem_ready;
    logic        f0, f1, ena, enb, inva, inc, sll8, sra1;
    logic        mem_write, mem_read, mem_fetch, busy, halted, err_illegal;
    logic [8:0]  cs_addr, mpc, c_en;
    logic [35:0] cs_data;
    logic [7:0]  mbr;
    logic [3:0]  b_sel;
    logic [23:0] ctl;

    logic [35:0] store [512];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_fetch = 0;
    logic prev_nz = 1'b0;

    typedef struct {
        logic [8:0] addr;
        int         gap;
    } fetch_t;
    fetch_t      exp_fetch [$];
    logic [23:0] exp_ctl   [$];

    mic1_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .cs_addr(cs_addr), .cs_rd(cs_rd),
        .cs_data(cs_data), .alu_n(alu_n), .alu_z(alu_z), .mbr(mbr),
        .mem_ready(mem_ready), .f0(f0), .f1(f1), .ena(ena), .enb(enb),
        .inva(inva), .inc(inc), .sll8(sll8), .sra1(sra1), .c_en(c_en),
        .b_sel(b_sel), .mem_write(mem_write), .mem_read(mem_read),
        .mem_fetch(mem_fetch), .mpc(mpc), .busy(busy), .halted(halted),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    assign ctl = {f0, f1, ena, enb, inva, inc, sll8, sra1, c_en, b_sel,
                  mem_write, mem_read, mem_fetch};

    function automatic logic [35:0] mk(input logic [8:0] nxt, input logic jmpc,
                                       input logic jamn, input logic jamz,
                                       input logic [5:0] alu, input logic [8:0] c,
                                       input logic wr, input logic rd,
                                       input logic fe, input logic [3:0] b);
        return {nxt, jmpc, jamn, jamz, 1'b0, 1'b0, alu, c, wr, rd, fe, b};
    endfunction

    function automatic logic [35:0] halt_at(input logic [8:0] a);
        return mk(a, 1'b0, 1'b0, 1'b0, 6'b011000, 9'h000, 1'b0, 1'b0, 1'b0, 4'h0);
    endfunction

    function automatic logic [23:0] exp_ctrl(input logic [35:0] m);
        return {m[21], m[20], m[19], m[18], m[17], m[16], m[23], m[22],
                m[15:7], m[3:0], m[6], m[5], m[4]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_fetch(input logic [8:0] a, input int gap);
        fetch_t f;
        f.addr = a;
        f.gap  = gap;
        exp_fetch.push_back(f);
    endtask

    task automatic push_ctl(input logic [35:0] m);
        exp_ctl.push_back(exp_ctrl(m));
    endtask

    // Synchronous control store: data appears the cycle after cs_rd.
    always @(negedge clk) begin
        if (cs_rd) cs_data = store[cs_addr];
    end

    // Monitor: pop and compare whenever the DUT fetches or drives a control word.
    always @(negedge clk) begin
        fetch_t f;
        cyc++;
        if (!rst) begin
            if (cs_rd) begin
                if (exp_fetch.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_fetch: got addr %0h expected no fetch", cs_addr);
                end else begin
                    f = exp_fetch.pop_front();
                    check("cs_addr", cs_addr, f.addr);
                    if (f.gap != 0) check("fetch_gap", cyc - last_fetch, f.gap);
                end
                last_fetch = cyc;
            end
            if (ctl != 24'h0) begin
                check("ctl_one_cycle", prev_nz, 1'b0);
                if (exp_ctl.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ctl: got %0h expected none", ctl);
                end else begin
                    check("ctl_word", ctl, exp_ctl.pop_front());
                end
            end
            prev_nz = (ctl != 24'h0);
        end else begin
            prev_nz = 1'b0;
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        alu_n     = 1'b0;
        alu_z     = 1'b0;
        mbr       = 8'h00;
        foreach (store[i]) store[i] = 36'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        int n = 0;
        while (!halted && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, halted, 1'b1);
    endtask

    // sel 0: wait for cs_rd; sel 1: wait for any memory strobe.
    task automatic wait_for(input int sel, input string name);
        int   n = 0;
        logic hit;
        hit = (sel == 0) ? cs_rd : (mem_read | mem_write | mem_fetch);
        while (!hit && n < 40) begin
            @(negedge clk);
            n++;
            hit = (sel == 0) ? cs_rd : (mem_read | mem_write | mem_fetch);
        end
        check(name, hit, 1'b1);
    endtask

    task automatic check_drained();
        check("fetch_pending", exp_fetch.size(), 0);
        check("ctl_pending", exp_ctl.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; alu_n = 1'b0; alu_z = 1'b0;
        mbr = 8'h00; cs_data = 36'h0;
        @(negedge clk);

        // Basic instruction, reset state, 3-cycle spacing, self-loop halt.
        do_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_cs_rd", cs_rd, 1'b0);
        check("rst_mpc", mpc, 9'h000);
        check("rst_ctl", ctl, 24'h0);
        check("rst_err", err_illegal, 1'b0);
        store[0] = mk(9'h005, 1'b0, 1'b0, 1'b0, 6'b111100, 9'h001, 1'b0, 1'b0, 1'b0, 4'h0);
        store[5] = halt_at(9'h005);
        push_fetch(9'h000, 0); push_fetch(9'h005, 3);
        push_ctl(store[0]); push_ctl(store[5]);
        run = 1'b1;
        wait_halted("t1_halt");
        check("t1_busy", busy, 1'b0);
        check("t1_mpc", mpc, 9'h005);
        repeat (8) @(negedge clk);
        check("t1_no_cs_rd", cs_rd, 1'b0);
        check("t1_still_halted", halted, 1'b1);
        check_drained();

        // JAMZ taken.
        do_reset();
        alu_z = 1'b1;
        store[0]     = mk(9'h010, 1'b0, 1'b0, 1'b1, 6'b110101, 9'h002, 1'b0, 1'b0, 1'b0, 4'h0);
        store[9'h110] = halt_at(9'h110);
        push_fetch(9'h000, 0); push_fetch(9'h110, 3);
        push_ctl(store[0]); push_ctl(store[9'h110]);
        run = 1'b1;
        wait_halted("jamz1_halt");
        check("jamz1_mpc", mpc, 9'h110);
        check_drained();

        // JAMZ not taken.
        do_reset();
        alu_z = 1'b0;
        store[0]     = mk(9'h010, 1'b0, 1'b0, 1'b1, 6'b110101, 9'h002, 1'b0, 1'b0, 1'b0, 4'h0);
        store[9'h010] = halt_at(9'h010);
        push_fetch(9'h000, 0); push_fetch(9'h010, 3);
        push_ctl(store[0]); push_ctl(store[9'h010]);
        run = 1'b1;
        wait_halted("jamz0_halt");
        check("jamz0_mpc", mpc, 9'h010);
        check_drained();

        // JMPC with a memory fetch and three WAIT cycles.
        do_reset();
        mbr = 8'h3C;
        store[0]     = mk(9'h100, 1'b1, 1'b0, 1'b0, 6'b010100, 9'h000, 1'b0, 1'b0, 1'b1, 4'h1);
        store[9'h13C] = halt_at(9'h13C);
        push_fetch(9'h000, 0); push_fetch(9'h13C, 6);
        push_ctl(store[0]); push_ctl(store[9'h13C]);
        run = 1'b1;
        wait_for(1, "jmpc_strobe");
        @(negedge clk);
        check("wait_busy", busy, 1'b1);
        check("wait_mpc_held", mpc, 9'h000);
        @(negedge clk);
        check("wait_no_cs_rd", cs_rd, 1'b0);
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        wait_halted("jmpc_halt");
        check("jmpc_mpc", mpc, 9'h13C);
        check_drained();

        // mem_ready already high: WAIT still lasts one cycle.
        do_reset();
        mem_ready = 1'b1;
        store[0] = mk(9'h007, 1'b0, 1'b0, 1'b0, 6'b011100, 9'h010, 1'b0, 1'b1, 1'b0, 4'h2);
        store[7] = halt_at(9'h007);
        push_fetch(9'h000, 0); push_fetch(9'h007, 4);
        push_ctl(store[0]); push_ctl(store[7]);
        run = 1'b1;
        wait_halted("minwait_halt");
        check("minwait_mpc", mpc, 9'h007);
        check_drained();

        // run dropped during LOAD, then resume at MPC.
        do_reset();
        store[0] = mk(9'h009, 1'b0, 1'b0, 1'b0, 6'b011000, 9'h004, 1'b0, 1'b0, 1'b0, 4'h0);
        store[9] = halt_at(9'h009);
        push_fetch(9'h000, 0); push_ctl(store[0]);
        run = 1'b1;
        wait_for(0, "drop_fetch");
        @(negedge clk);
        run = 1'b0;
        repeat (4) @(negedge clk);
        check("drop_busy", busy, 1'b0);
        check("drop_halted", halted, 1'b0);
        check("drop_mpc", mpc, 9'h009);
        check("drop_no_cs_rd", cs_rd, 1'b0);
        push_fetch(9'h009, 0); push_ctl(store[9]);
        run = 1'b1;
        wait_halted("resume_halt");
        check("resume_mpc", mpc, 9'h009);
        check_drained();

        // Asynchronous reset while in WAIT.
        do_reset();
        store[0] = mk(9'h006, 1'b0, 1'b0, 1'b0, 6'b011000, 9'h001, 1'b0, 1'b0, 1'b0, 4'h0);
        store[6] = mk(9'h003, 1'b0, 1'b0, 1'b0, 6'b010000, 9'h080, 1'b0, 1'b1, 1'b0, 4'h3);
        push_fetch(9'h000, 0); push_fetch(9'h006, 3);
        push_ctl(store[0]); push_ctl(store[6]);
        run = 1'b1;
        wait_for(1, "rstwait_strobe");
        @(negedge clk);
        check("rstwait_mpc_pre", mpc, 9'h006);
        check("rstwait_busy_pre", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rstwait_mpc", mpc, 9'h000);
        check("rstwait_busy", busy, 1'b0);
        check("rstwait_cs_rd", cs_rd, 1'b0);
        check("rstwait_ctl", ctl, 24'h0);
        @(negedge clk);
        check_drained();

        // Illegal ALU encoding 000001.
        do_reset();
        mem_ready = 1'b1;
        store[0] = mk(9'h004, 1'b0, 1'b0, 1'b0, 6'b000001, 9'h008, 1'b1, 1'b0, 1'b0, 4'h0);
`ifdef MIC1_SEQ_ILLEGAL_ALU_CHECK_EN
        push_fetch(9'h000, 0);
        push_ctl(mk(9'h004, 1'b0, 1'b0, 1'b0, 6'b000001, 9'h000, 1'b0, 1'b0, 1'b0, 4'h0));
        run = 1'b1;
        wait_halted("illegal_halt");
        check("illegal_err", err_illegal, 1'b1);
        check("illegal_busy", busy, 1'b0);
`else
        store[4] = halt_at(9'h004);
        push_fetch(9'h000, 0); push_fetch(9'h004, 4);
        push_ctl(store[0]); push_ctl(store[4]);
        run = 1'b1;
        wait_halted("illegal_halt");
        check("illegal_err", err_illegal, 1'b0);
        check("illegal_mpc", mpc, 9'h004);
`endif
        check_drained();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
